// File: rtl/bank_cmd_arbiter.sv
// Round-robin issue arbiter between the per-bank FSMs and the DRAM command pins.
// Picks at most one timing-legal request per cycle, releases stall for that bank
// only, and registers the resulting DRAM command one cycle later.
module bank_cmd_arbiter #(
  parameter int unsigned NUM_BANKS = 8,
  parameter int unsigned BA_BITS   = 3,
  parameter int unsigned ADDR_BITS = 14,
  parameter int unsigned T_RCD     = 3,
  parameter int unsigned T_RP      = 3,
  parameter int unsigned T_CCD     = 2,
  parameter int unsigned T_AP      = 6
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_BANKS-1:0]           req,
  input  logic [2*NUM_BANKS-1:0]         req_type,
  input  logic [ADDR_BITS*NUM_BANKS-1:0] req_addr,
  output logic [NUM_BANKS-1:0]           stall,
  output logic                           cmd_valid,
  output logic [2:0]                     cmd_type,
  output logic [BA_BITS-1:0]             cmd_bank,
  output logic [ADDR_BITS-1:0]           cmd_addr
);

  localparam logic [1:0] ReqAct   = 2'b00;
  localparam logic [1:0] ReqRead  = 2'b01;
  localparam logic [1:0] ReqWrite = 2'b10;
  localparam logic [1:0] ReqPre   = 2'b11;
  localparam logic [2:0] CmdNop   = 3'b000;

  localparam int unsigned TMax01 = (T_RCD > T_RP) ? T_RCD : T_RP;
  localparam int unsigned TMax23 = (T_CCD > T_AP) ? T_CCD : T_AP;
  localparam int unsigned TMax   = (TMax01 > TMax23) ? TMax01 : TMax23;
  // Counters only ever hold T_x-1.
  localparam int unsigned CntW   = (TMax > 2) ? $clog2(TMax) : 1;

  typedef logic [CntW-1:0] cnt_t;

  cnt_t act_cnt_q [NUM_BANKS];
  cnt_t act_cnt_d [NUM_BANKS];
  cnt_t rcd_cnt_q [NUM_BANKS];
  cnt_t rcd_cnt_d [NUM_BANKS];
  cnt_t ccd_cnt_q, ccd_cnt_d;

  logic [BA_BITS-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NUM_BANKS-1:0] elig;
  logic                 gnt_vld;
  logic [BA_BITS-1:0]   gnt_idx;
  logic [BA_BITS-1:0]   scan_idx;
  logic [1:0]           gnt_type;
  logic [ADDR_BITS-1:0] gnt_addr;

  logic                 cmd_valid_q;
  logic [2:0]           cmd_type_q;
  logic [BA_BITS-1:0]   cmd_bank_q;
  logic [ADDR_BITS-1:0] cmd_addr_q;

  // Per-bank eligibility: pending request whose timing constraint has expired.
  always_comb begin
    elig = '0;
    for (int i = 0; i < int'(NUM_BANKS); i++) begin
      case (req_type[2*i +: 2])
        ReqAct:            elig[i] = req[i] && (act_cnt_q[i] == '0);
        ReqRead, ReqWrite: elig[i] = req[i] && (rcd_cnt_q[i] == '0) && (ccd_cnt_q == '0);
        default:           elig[i] = req[i];
      endcase
    end
  end

  // Round-robin scan from rr_ptr; first eligible bank wins. No grant while in reset.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    scan_idx = '0;
    for (int unsigned off = 0; off < NUM_BANKS; off++) begin
      scan_idx = BA_BITS'((32'(rr_ptr_q) + off) % NUM_BANKS);
      if (!gnt_vld && elig[scan_idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = scan_idx;
      end
    end
    if (!rst_n) gnt_vld = 1'b0;
  end

  assign gnt_type = req_type[2*gnt_idx +: 2];
  assign gnt_addr = req_addr[ADDR_BITS*gnt_idx +: ADDR_BITS];

  // Only the granted bank sees stall low.
  always_comb begin
    stall = '1;
    if (gnt_vld) stall[gnt_idx] = 1'b0;
  end

  // Timing counters: saturating decrement, a grant-time load overrides it.
  always_comb begin
    for (int i = 0; i < int'(NUM_BANKS); i++) begin
      act_cnt_d[i] = (act_cnt_q[i] == '0) ? '0 : act_cnt_q[i] - cnt_t'(1);
      rcd_cnt_d[i] = (rcd_cnt_q[i] == '0) ? '0 : rcd_cnt_q[i] - cnt_t'(1);
    end
    ccd_cnt_d = (ccd_cnt_q == '0) ? '0 : ccd_cnt_q - cnt_t'(1);
    rr_ptr_d  = rr_ptr_q;
    if (gnt_vld) begin
      rr_ptr_d = (gnt_idx == BA_BITS'(NUM_BANKS - 1)) ? '0 : gnt_idx + BA_BITS'(1);
      case (gnt_type)
        ReqAct: rcd_cnt_d[gnt_idx] = cnt_t'(T_RCD - 1);
        ReqPre: act_cnt_d[gnt_idx] = cnt_t'(T_RP - 1);
        default: begin
          ccd_cnt_d = cnt_t'(T_CCD - 1);
          // Address bit 10 requests auto-precharge; the bank closes itself.
          if (gnt_addr[10]) act_cnt_d[gnt_idx] = cnt_t'(T_AP - 1);
        end
      endcase
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_BANKS); i++) begin
        act_cnt_q[i] <= '0;
        rcd_cnt_q[i] <= '0;
      end
      ccd_cnt_q <= '0;
      rr_ptr_q  <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_BANKS); i++) begin
        act_cnt_q[i] <= act_cnt_d[i];
        rcd_cnt_q[i] <= rcd_cnt_d[i];
      end
      ccd_cnt_q <= ccd_cnt_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  // Registered DRAM command bus; bank/addr hold when nothing is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_valid_q <= 1'b0;
      cmd_type_q  <= CmdNop;
      cmd_bank_q  <= '0;
      cmd_addr_q  <= '0;
    end else begin
      cmd_valid_q <= gnt_vld;
      cmd_type_q  <= gnt_vld ? ({1'b0, gnt_type} + 3'd1) : CmdNop;
      if (gnt_vld) begin
        cmd_bank_q <= gnt_idx;
        cmd_addr_q <= gnt_addr;
      end
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_type  = cmd_type_q;
  assign cmd_bank  = cmd_bank_q;
  assign cmd_addr  = cmd_addr_q;

endmodule

// File: tb/tb_bank_cmd_arbiter.sv
// Directed bench for bank_cmd_arbiter: stimulus pushes expected DRAM commands
// into a queue, a negedge monitor pops and compares whenever cmd_valid is high.
module tb_bank_cmd_arbiter;

  localparam int NB = 8;
  localparam int AB = 14;

  localparam logic [1:0] ACT = 2'b00;
  localparam logic [1:0] RD  = 2'b01;
  localparam logic [1:0] WR  = 2'b10;
  localparam logic [1:0] PRE = 2'b11;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NB-1:0]     req;
  logic [2*NB-1:0]   req_type;
  logic [AB*NB-1:0]  req_addr;
  logic [NB-1:0]     stall;
  logic              cmd_valid;
  logic [2:0]        cmd_type;
  logic [2:0]        cmd_bank;
  logic [AB-1:0]     cmd_addr;

  typedef struct packed {
    logic [2:0]    t;
    logic [2:0]    b;
    logic [AB-1:0] a;
  } cmd_t;

  cmd_t exp_q[$];
  cmd_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  bank_cmd_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_type  (req_type),
    .req_addr  (req_addr),
    .stall     (stall),
    .cmd_valid (cmd_valid),
    .cmd_type  (cmd_type),
    .cmd_bank  (cmd_bank),
    .cmd_addr  (cmd_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_req(input int b, input logic [1:0] t, input logic [AB-1:0] a);
    req[b]              = 1'b1;
    req_type[2*b +: 2]  = t;
    req_addr[AB*b +: AB] = a;
  endtask

  // One arbitration cycle: check stall, queue the command the granted bank should
  // produce, then retire that bank's request as the bank FSM would.
  task automatic step(input logic [NB-1:0] exp_stall, input string nm);
    int g;
    cmd_t e;
    g = -1;
    @(negedge clk);
    check(nm, 32'(stall), 32'(exp_stall));
    for (int i = 0; i < NB; i++) begin
      if (!exp_stall[i]) begin
        g   = i;
        e.t = {1'b0, req_type[2*i +: 2]} + 3'd1;
        e.b = 3'(i);
        e.a = req_addr[AB*i +: AB];
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    if (g >= 0) req[g] = 1'b0;
  endtask

  // Monitor: every issued command must match the oldest expected one.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && cmd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected cmd: got type %0d bank %0d addr %h, none expected",
                 cmd_type, cmd_bank, cmd_addr);
      end else begin
        mon_e = exp_q.pop_front();
        check("cmd", 32'({cmd_type, cmd_bank, cmd_addr}), 32'(mon_e));
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    req      = '1;
    req_type = '0;
    req_addr = '0;

    // Test 1: reset state with every bank requesting.
    repeat (2) @(negedge clk);
    check("rst stall", 32'(stall), 32'h0000_00FF);
    check("rst cmd_valid", 32'(cmd_valid), 32'h0);
    check("rst cmd_type", 32'(cmd_type), 32'h0);
    check("rst cmd_bank", 32'(cmd_bank), 32'h0);
    check("rst cmd_addr", 32'(cmd_addr), 32'h0);
    @(posedge clk);
    #1;
    req = '0;
    set_req(2, ACT, 14'h155);
    rst_n = 1'b1;
    step(8'hFB, "t1 grant b2");

    // Test 2: tRCD from ACT to READ on bank 0.
    set_req(0, ACT, 14'h0AA);
    step(8'hFE, "t2 act b0");
    set_req(0, RD, 14'h010);
    step(8'hFF, "t2 rcd N+1");
    step(8'hFF, "t2 rcd N+2");
    step(8'hFE, "t2 read N+3");

    // Move rr_ptr to 5 with a PRE on bank 4.
    set_req(4, PRE, 14'h3FF);
    step(8'hEF, "t3 prep pre b4");
    step(8'hFF, "t3 idle");

    // Test 3: banks 1,4,7 ACT from rr_ptr=5 -> 7, 1, 4 (wraps through 0).
    set_req(1, ACT, 14'h111);
    set_req(4, ACT, 14'h044);
    set_req(7, ACT, 14'h077);
    step(8'h7F, "t3 grant b7");
    step(8'hFD, "t3 grant b1");
    step(8'hEF, "t3 grant b4");

    // rr_ptr must now be 5: bank 6 beats bank 4.
    set_req(4, PRE, 14'h200);
    set_req(6, PRE, 14'h066);
    step(8'hBF, "rr5 grant b6");
    step(8'hEF, "rr5 grant b4");
    set_req(7, PRE, 14'h007);
    step(8'h7F, "rr0 grant b7");

    // Test 4: READs on banks 3 and 5 separated by tCCD.
    set_req(3, RD, 14'h033);
    set_req(5, RD, 14'h055);
    step(8'hF7, "t4 read b3");
    step(8'hFF, "t4 ccd b5");
    step(8'hDF, "t4 read b5");

    // Test 5: WRITE with auto-precharge on bank 6 (also blocked one cycle by tCCD).
    set_req(6, WR, 14'h400);
    step(8'hFF, "t5 ccd b6");
    step(8'hBF, "t5 write ap b6");
    set_req(6, ACT, 14'h123);
    for (int i = 1; i <= 5; i++) step(8'hFF, $sformatf("t5 tap N+%0d", i));
    step(8'hBF, "t5 act N+6");

    // Test 6: reset asserted while a grant is pending.
    set_req(1, ACT, 14'h0F0);
    @(negedge clk);
    check("t6 grant b1", 32'(stall), 32'h0000_00FD);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6 rst cmd_valid", 32'(cmd_valid), 32'h0);
    check("t6 rst stall", 32'(stall), 32'h0000_00FF);
    req = '0;
    @(posedge clk);
    #1;
    check("t6 rst hold cmd_valid", 32'(cmd_valid), 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(8'hFF, "t6 idle after reset");

    // rr_ptr and counters cleared by reset: bank 0 then 7.
    set_req(0, ACT, 14'h001);
    set_req(7, ACT, 14'h7FF);
    step(8'hFE, "t6 post grant b0");
    step(8'h7F, "t6 post grant b7");

    repeat (3) @(negedge clk);
    check("queue drained", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bank_cmd_arbiter.md
Name: bank_cmd_arbiter

Overview:
- Responder side of the per-bank issue handshake.
- Each bank FSM presents a pending ACT/READ/WRITE/PRE request while sitting in its *_CHECK state. This block picks at most one legal request per cycle (round-robin, with per-bank and global DRAM timing checks).
- It drops `stall` only for the granted bank, then drives the registered DRAM command bus one cycle later.
- Sits between the NUM_BANKS bank FSMs and the DRAM command/address pins.

Parameters:
- NUM_BANKS, 8, number of bank FSMs served.
- BA_BITS, 3, bank index width; equals log2(NUM_BANKS).
- ADDR_BITS, 14, row/column address width.
- T_RCD, 3, minimum cycles from ACT grant to READ/WRITE grant, same bank.
- T_RP, 3, minimum cycles from PRE grant to ACT grant, same bank.
- T_CCD, 2, minimum cycles between any two column (READ/WRITE) grants, all banks.
- T_AP, 6, minimum cycles from auto-precharge column grant to ACT grant, same bank.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req  input  NUM_BANKS  bit i = bank i has a pending command.
- req_type  input  2*NUM_BANKS  per bank: 00 ACT, 01 READ, 10 WRITE, 11 PRE.
- req_addr  input  ADDR_BITS*NUM_BANKS  per bank: row for ACT, column for READ/WRITE, don't-care for PRE.
- stall  output  NUM_BANKS  bit i low = bank i granted this cycle.
- cmd_valid  output  1  DRAM command valid.
- cmd_type  output  3  000 NOP, 001 ACT, 010 READ, 011 WRITE, 100 PRE.
- cmd_bank  output  BA_BITS  target bank.
- cmd_addr  output  ADDR_BITS  address for the command.

Behaviour:
Reset (rst_n low, asynchronous):
- stall all ones; cmd_valid 0; cmd_type NOP; cmd_bank 0; cmd_addr 0.
- rr_ptr 0; all timing counters 0.
- Assertion mid-grant discards the pending command; no cmd_valid follows.

Request handshake:
- A request is held stable by the bank until the cycle it sees stall low.
- Changing req_type or req_addr while req is high and ungranted is illegal.

Eligibility (bank i):
- req[i]=1, plus the timing check for its type:
  - ACT: act_cnt[i]==0.
  - READ/WRITE: rcd_cnt[i]==0 and ccd_cnt==0.
  - PRE: always eligible.

Grant (combinational):
- Scan eligible banks starting at rr_ptr, ascending, wrapping NUM_BANKS-1 to 0. The first hit g is granted.
- stall[g]=0; every other stall bit is 1. With no eligible bank, all stall bits are 1.
- Exactly one grant at most per cycle.

On the clock edge after grant to g:
- cmd_valid=1; cmd_type from req_type[g] (ACT→001, READ→010, WRITE→011, PRE→100); cmd_bank=g; cmd_addr=req_addr[g].
- rr_ptr = (g+1) mod NUM_BANKS.
- No grant: cmd_valid=0, cmd_type=NOP; cmd_bank/cmd_addr hold their previous values.

Counters (per bank, decrement to 0 each cycle, saturating at 0):
- ACT grant to g: rcd_cnt[g]=T_RCD-1.
- PRE grant to g: act_cnt[g]=T_RP-1.
- READ/WRITE grant: ccd_cnt=T_CCD-1. If req_addr[g][10]=1 (auto-precharge), also act_cnt[g]=T_AP-1.
- Result: a grant at cycle N allows the next dependent grant at exactly N+T_x.
- A load in the same cycle as a decrement: the load wins.

Boundary and simultaneous cases:
- All banks requesting: grants rotate strictly round-robin.
- Ineligible banks are skipped without consuming priority; rr_ptr moves only on a grant.
- Wrap-around: grant to bank NUM_BANKS-1 sets rr_ptr=0.
- No grants: rr_ptr and cmd fields hold.

Latency:
- Request→stall low: 0 cycles when eligible.
- Grant→cmd_valid: 1 cycle.

Test Plan:
1. Reset with req=8'hFF → stall=8'hFF, cmd_valid=0. Release reset with only bank 2 requesting ACT, addr 0x155 → stall[2]=0 in the same cycle; next cycle cmd_valid=1, cmd_type=001, cmd_bank=2, cmd_addr=0x155.
2. Bank 0 ACT granted at cycle N, then READ held immediately → stall[0]=1 through N+2; granted at N+3 (T_RCD=3); cmd_type=010 at N+4.
3. Banks 1, 4, 7 all request ACT with rr_ptr=5 → grant order 7, 1, 4 on consecutive cycles; rr_ptr ends at 5.
4. Banks 3 and 5 request READ in the same cycle, rcd satisfied, rr_ptr=0 → bank 3 at N, bank 5 at N+2 (T_CCD=2); bank 5 stalled at N+1.
5. Bank 6 WRITE with addr bit10=1 at N, then ACT requested → ACT granted no earlier than N+6 (T_AP).
6. rst_n dropped asynchronously the cycle after a grant → cmd_valid=0 immediately, stall all ones, no command issued after release.
